// File: rtl/ps2_tx_if.sv
// Command-side handshake between a PS/2 host controller and ps2_tx.
// The master issues wr_ps2/din; the slave (ps2_tx) reports idle/done/error.
interface ps2_tx_if;
   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err;

   modport master (
      output wr_ps2,
      output din,
      input  tx_idle,
      input  tx_done_tick,
      input  tx_err
   );

   modport slave (
      input  wr_ps2,
      input  din,
      output tx_idle,
      output tx_done_tick,
      output tx_err
   );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter over open-drain ps2c/ps2d.
// Define PS2_TX_RETRY_EN to retry once automatically after a NACK or timeout.
module ps2_tx #(
   parameter int unsigned RTS_CYCLES     = 5000,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic    clk,
   input  logic    reset_n,
   ps2_tx_if.slave cmd,
   input  logic    ps2c_in,
   input  logic    ps2d_in,
   output logic    ps2c_oe,
   output logic    ps2d_oe
);

   localparam int unsigned RTS_W = $clog2(RTS_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

   localparam logic [RTS_W-1:0] RTS_LOAD = RTS_W'(RTS_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RTS,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_REL,
      S_RETRY
   } state_t;

   // line conditioning
   logic [1:0]       c_sync_q;
   logic [1:0]       d_sync_q;
   logic             c_filt_q;
   logic [FLT_W-1:0] flt_cnt_q;
   logic             fall_q;
   logic             d_s;

   // control state
   state_t           state_q, state_d;
   logic [RTS_W-1:0] rts_cnt_q, rts_cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [8:0]       frame_q, frame_d;
   logic [8:0]       shift_q, shift_d;
   logic [3:0]       bit_q, bit_d;
`ifdef PS2_TX_RETRY_EN
   logic             nack_q, nack_d;
   logic             retried_q, retried_d;
`endif

   // registered outputs
   logic             c_oe_q, c_oe_d;
   logic             d_oe_q, d_oe_d;
   logic             idle_q, idle_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   assign d_s = d_sync_q[1];

   // Lines idle high, so synchronisers and filter reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_sync_q  <= '1;
         d_sync_q  <= '1;
         c_filt_q  <= 1'b1;
         flt_cnt_q <= '0;
         fall_q    <= 1'b0;
      end else begin
         c_sync_q <= {c_sync_q[0], ps2c_in};
         d_sync_q <= {d_sync_q[0], ps2d_in};
         fall_q   <= 1'b0;
         if (c_sync_q[1] == c_filt_q) begin
            flt_cnt_q <= '0;
         end else if (flt_cnt_q == FLT_LAST) begin
            c_filt_q  <= c_sync_q[1];
            flt_cnt_q <= '0;
            fall_q    <= c_filt_q;
         end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rts_cnt_q <= '0;
         tmo_q     <= '0;
         frame_q   <= '0;
         shift_q   <= '0;
         bit_q     <= '0;
`ifdef PS2_TX_RETRY_EN
         nack_q    <= 1'b0;
         retried_q <= 1'b0;
`endif
         c_oe_q    <= 1'b0;
         d_oe_q    <= 1'b0;
         idle_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rts_cnt_q <= rts_cnt_d;
         tmo_q     <= tmo_d;
         frame_q   <= frame_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
`ifdef PS2_TX_RETRY_EN
         nack_q    <= nack_d;
         retried_q <= retried_d;
`endif
         c_oe_q    <= c_oe_d;
         d_oe_q    <= d_oe_d;
         idle_q    <= idle_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rts_cnt_d = rts_cnt_q;
      tmo_d     = tmo_q;
      frame_d   = frame_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      err_d     = err_q;
`ifdef PS2_TX_RETRY_EN
      nack_d    = nack_q;
      retried_d = retried_q;
`endif
      case (state_q)
         S_IDLE: begin
            // done_q marks the return cycle; a strobe landing there is dropped.
            if (cmd.wr_ps2 && !done_q) begin
               frame_d   = {~^cmd.din, cmd.din};
               err_d     = 1'b0;
               rts_cnt_d = RTS_LOAD;
               state_d   = S_RTS;
`ifdef PS2_TX_RETRY_EN
               nack_d    = 1'b0;
               retried_d = 1'b0;
`endif
            end
         end

         S_RTS: begin
            shift_d = frame_q;
            bit_d   = '0;
            if (rts_cnt_q == '0) begin
               tmo_d   = TMO_LOAD;
               state_d = S_START;
            end else begin
               rts_cnt_d = rts_cnt_q - 1'b1;
            end
         end

         S_START, S_DATA, S_STOP, S_WAIT_REL: begin
            if (tmo_q == '0) begin
`ifdef PS2_TX_RETRY_EN
               if (!retried_q) begin
                  rts_cnt_d = RTS_LOAD;
                  state_d   = S_RETRY;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
`else
               err_d   = 1'b1;
               state_d = S_IDLE;
`endif
            end else begin
               tmo_d = tmo_q - 1'b1;
               case (state_q)
                  S_START: begin
                     if (fall_q) state_d = S_DATA;
                  end
                  S_DATA: begin
                     if (fall_q) begin
                        if (bit_q == 4'd8) begin
                           state_d = S_STOP;
                        end else begin
                           shift_d = {1'b0, shift_q[8:1]};
                           bit_d   = bit_q + 4'd1;
                        end
                     end
                  end
                  S_STOP: begin
                     if (fall_q) begin
                        state_d = S_WAIT_REL;
                        if (d_s) begin
`ifdef PS2_TX_RETRY_EN
                           if (retried_q) err_d  = 1'b1;
                           else           nack_d = 1'b1;
`else
                           err_d = 1'b1;
`endif
                        end
                     end
                  end
                  S_WAIT_REL: begin
                     if (c_filt_q && d_s) begin
`ifdef PS2_TX_RETRY_EN
                        if (nack_q) begin
                           rts_cnt_d = RTS_LOAD;
                           state_d   = S_RETRY;
                        end else begin
                           state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                     end
                  end
                  default: ;
               endcase
            end
         end

`ifdef PS2_TX_RETRY_EN
         S_RETRY: begin
            if (rts_cnt_q == '0) begin
               rts_cnt_d = RTS_LOAD;
               retried_d = 1'b1;
               nack_d    = 1'b0;
               state_d   = S_RTS;
            end else begin
               rts_cnt_d = rts_cnt_q - 1'b1;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      c_oe_d = (state_d == S_RTS);
      case (state_d)
         S_START: d_oe_d = 1'b1;
         S_DATA:  d_oe_d = ~shift_d[0];
         default: d_oe_d = 1'b0;
      endcase
      idle_d = (state_d == S_IDLE);
      done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
   end

   assign ps2c_oe          = c_oe_q;
   assign ps2d_oe          = d_oe_q;
   assign cmd.tx_idle      = idle_q;
   assign cmd.tx_done_tick = done_q;
   assign cmd.tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx: a keyboard model clocks frames out of the DUT,
// a monitor pops the expected outcome on every tx_done_tick.
module tb_ps2_tx;
   localparam int unsigned RTS  = 20;
   localparam int unsigned FLT  = 3;
   localparam int unsigned TMO  = 5000;
   localparam int          ACK    = 0;
   localparam int          NACK   = 1;
   localparam int          SILENT = 2;

   typedef struct {
      logic        err;
      int unsigned nframes;
      logic [10:0] frame;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic dev_c   = 1'b1;
   logic dev_d   = 1'b1;
   logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;

   ps2_tx_if bus ();

   exp_t        exp_q[$];
   logic [10:0] rx_q[$];
   exp_t        e_mon;
   logic [10:0] f_mon;
   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned done_cnt = 0;
   int unsigned exp_done = 0;
   int unsigned cyc      = 0;
   int unsigned done_cyc = 0;
   int unsigned rel_cyc  = 0;

   assign ps2c_in = dev_c & ~ps2c_oe;
   assign ps2d_in = dev_d & ~ps2d_oe;

   ps2_tx #(
      .RTS_CYCLES     (RTS),
      .FILTER_LEN     (FLT),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cmd     (bus),
      .ps2c_in (ps2c_in),
      .ps2d_in (ps2d_in),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Wire image as the device sees it: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] wire_frame(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2 == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_xfer(input logic [7:0] b, input logic err, input int unsigned nf);
      exp_t e;
      e.err     = err;
      e.nframes = nf;
      e.frame   = wire_frame(b);
      exp_q.push_back(e);
      exp_done++;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.din    = b;
      bus.wr_ps2 = 1'b1;
      @(negedge clk);
      bus.wr_ps2 = 1'b0;
      bus.din    = 8'($urandom);
   endtask

   task automatic wait_done(input int unsigned target);
      int unsigned n;
      n = 0;
      while (done_cnt < target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt < target) chk("done_seen", 0, 1);
      @(negedge clk);
   endtask

   task automatic low_phase(input bit g);
      if (g) begin
         repeat (40) @(negedge clk);
         dev_c = 1'b1;
         @(negedge clk);
         dev_c = 1'b0;
         repeat (59) @(negedge clk);
      end else begin
         repeat (100) @(negedge clk);
      end
   endtask

   // Keyboard model: observes request-to-send, then clocks nfalls falling edges.
   task automatic dev_xfer(input int mode, input bit glitch, input int unsigned nfalls);
      int unsigned n;
      logic        d_seen;
      logic [10:0] f;
      n      = 0;
      d_seen = 1'b0;
      f      = '0;
      while (!ps2c_oe && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!ps2c_oe) begin
         chk("rts_seen", 0, 1);
         return;
      end
      n = 0;
      while (ps2c_oe && n < 1000) begin
         if (ps2d_oe) d_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("rts_len", n, RTS);
      chk("rts_data_released", d_seen, 0);
      rel_cyc = cyc;
      f[0]    = ps2d_in;
      if (mode == SILENT) return;
      repeat (50) @(negedge clk);
      for (int unsigned k = 1; k <= nfalls; k++) begin
         dev_c = 1'b0;
         low_phase(glitch);
         dev_c = 1'b1;
         if (k <= 10) f[4'(k)] = ps2d_in;
         if (k == 11) begin
            dev_d = 1'b1;
            rx_q.push_back(f);
         end else begin
            repeat (40) @(negedge clk);
            if (glitch) begin
               dev_c = 1'b0;
               repeat (2) @(negedge clk);
               dev_c = 1'b1;
               repeat (8) @(negedge clk);
            end else begin
               repeat (10) @(negedge clk);
            end
            if (k == 10 && mode == ACK) dev_d = 1'b0;
            repeat (50) @(negedge clk);
         end
      end
   endtask

   task automatic xfer(input logic [7:0] b, input bit glitch);
      expect_xfer(b, 1'b0, 1);
      send(b);
      dev_xfer(ACK, glitch, 11);
      wait_done(exp_done);
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.tx_done_tick) begin
         done_cnt++;
         done_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            e_mon = exp_q.pop_front();
            chk("done_err", bus.tx_err, e_mon.err);
            chk("done_idle", bus.tx_idle, 1);
            chk("done_lines_released", {ps2c_oe, ps2d_oe}, 0);
            for (int k = 0; k < int'(e_mon.nframes); k++) begin
               if (rx_q.size() == 0) begin
                  chk("frame_present", 0, 1);
               end else begin
                  f_mon = rx_q.pop_front();
                  chk("frame_bits", f_mon, e_mon.frame);
               end
            end
         end
      end
   end

   initial begin
      int unsigned n;
      int unsigned delta;
      int unsigned snap;
      logic [7:0]  b;
      bus.wr_ps2 = 1'b0;
      bus.din    = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_c_oe", ps2c_oe, 0);
      chk("reset_d_oe", ps2d_oe, 0);
      chk("reset_idle", bus.tx_idle, 1);
      chk("reset_done", bus.tx_done_tick, 0);
      chk("reset_err", bus.tx_err, 0);
      reset_n = 1'b1;
      @(negedge clk);

      xfer(8'hED, 1'b0);
      xfer(8'hF4, 1'b0);
      xfer(8'h00, 1'b0);

      // NACK, then a new command clears tx_err on acceptance
`ifdef PS2_TX_RETRY_EN
      expect_xfer(8'hAB, 1'b1, 2);
      send(8'hAB);
      dev_xfer(NACK, 1'b0, 11);
      dev_xfer(NACK, 1'b0, 11);
`else
      expect_xfer(8'hAB, 1'b1, 1);
      send(8'hAB);
      dev_xfer(NACK, 1'b0, 11);
`endif
      wait_done(exp_done);
      expect_xfer(8'hFF, 1'b0, 1);
      send(8'hFF);
      chk("err_clear_on_accept", bus.tx_err, 0);
      chk("busy_after_accept", bus.tx_idle, 0);
      dev_xfer(ACK, 1'b0, 11);
      wait_done(exp_done);

      // silent device -> timeout
      expect_xfer(8'h5A, 1'b1, 0);
      send(8'h5A);
      dev_xfer(SILENT, 1'b0, 0);
`ifdef PS2_TX_RETRY_EN
      dev_xfer(SILENT, 1'b0, 0);
      wait_done(exp_done);
`else
      wait_done(exp_done);
      delta = done_cyc - rel_cyc;
      chk("timeout_len", (delta >= TMO - 2 && delta <= TMO + 2), 1);
`endif

      // second strobe during data is dropped
      expect_xfer(8'hC3, 1'b0, 1);
      send(8'hC3);
      fork
         dev_xfer(ACK, 1'b0, 11);
         begin
            repeat (800) @(negedge clk);
            bus.din    = 8'h55;
            bus.wr_ps2 = 1'b1;
            @(negedge clk);
            bus.wr_ps2 = 1'b0;
         end
      join
      wait_done(exp_done);
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (ps2c_oe) n++;
      end
      chk("no_start_after_busy_wr", n, 0);

      // strobe on the done cycle is dropped
      expect_xfer(8'h81, 1'b0, 1);
      send(8'h81);
      dev_xfer(ACK, 1'b0, 11);
      n = 0;
      while (!bus.tx_done_tick && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("done_tick_seen", bus.tx_done_tick, 1);
      bus.din    = 8'h99;
      bus.wr_ps2 = 1'b1;
      @(negedge clk);
      bus.wr_ps2 = 1'b0;
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (ps2c_oe) n++;
      end
      chk("no_start_after_done_wr", n, 0);

      // glitches on ps2c while data shifts
      xfer(8'hA5, 1'b1);

      // asynchronous reset in the middle of data
      snap = done_cnt;
      send(8'h6E);
      dev_xfer(ACK, 1'b0, 4);
      chk("mid_data_busy", bus.tx_idle, 0);
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("async_reset_c_oe", ps2c_oe, 0);
      chk("async_reset_d_oe", ps2d_oe, 0);
      chk("async_reset_idle", bus.tx_idle, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("reset_no_done", done_cnt, snap);
      chk("reset_err_clear", bus.tx_err, 0);

      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         xfer(b, 1'($urandom_range(0, 1)));
      end

`ifdef PS2_TX_RETRY_EN
      expect_xfer(8'h3A, 1'b0, 2);
      send(8'h3A);
      dev_xfer(NACK, 1'b0, 11);
      dev_xfer(ACK, 1'b0, 11);
      wait_done(exp_done);
`endif

      repeat (50) @(negedge clk);
      chk("expected_drained", 32'(exp_q.size()), 0);
      chk("frames_drained", 32'(rx_q.size()), 0);
      chk("done_count", done_cnt, exp_done);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same open-drain ps2c/ps2d pair that the scan-code receive path listens on. Performs request-to-send, shifts out 8 data bits LSB-first plus odd parity, releases for the stop bit, checks the device ACK, and reports done/error. Its tx_idle output gates the receiver's rx_en so the two directions never overlap.

Parameters:
RTS_CYCLES, 5000, clk cycles ps2c is held low for request-to-send (100 us at 50 MHz); minimum 2.
FILTER_LEN, 8, consecutive identical synchronised ps2c samples needed to accept a level change.
TIMEOUT_CYCLES, 750000, maximum clk cycles from ps2c release to end of ACK (15 ms at 50 MHz).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
wr_ps2  in  1  one-cycle strobe: start sending din; ignored unless tx_idle=1
din  in  8  command byte, sampled on the wr_ps2 cycle
ps2c_in  in  1  raw ps2c line level (from IOBUF)
ps2d_in  in  1  raw ps2d line level (from IOBUF)
ps2c_oe  out  1  1 = drive ps2c low; 0 = release (pulled up)
ps2d_oe  out  1  1 = drive ps2d low; 0 = release
tx_idle  out  1  1 when no transfer is in progress; tie to receiver rx_en
tx_done_tick  out  1  one-cycle pulse at the end of every transfer (success or failure)
tx_err  out  1  1 = last transfer NACKed or timed out; held until the next accepted wr_ps2

Behaviour:
- Reset (reset_n=0, any time, including mid-transfer): state=idle; ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, tx_err=0; filter and counters cleared. Both lines are released immediately.
- All outputs are registered. ps2c_in and ps2d_in pass through 2-FF synchronisers. ps2c then goes through the FILTER_LEN filter. fall_edge is a one-cycle strobe on a filtered 1->0 transition.
- Odd parity: par = ~^din. Shift register = {par, din}, 9 bits, sent LSB first.
- idle: tx_idle=1. On wr_ps2: latch shift register, clear tx_err, load the RTS counter, go to rts. ps2c_oe=1 on the next cycle.
- rts: ps2c_oe=1, ps2d_oe=0 for RTS_CYCLES cycles. Then go to start.
- start: ps2c_oe=0, ps2d_oe=1 (start bit 0). Load the timeout counter. On fall_edge 1: bit index n=0, go to data.
- data: ps2d_oe = ~shift[0]. On each fall_edge: if n==8, go to stop; else shift right and n=n+1. Falls 2..9 present d1..d7 and parity.
- stop: ps2d_oe=0 (stop bit 1), entered at fall 10. On the next fall_edge (fall 11), sample synchronised ps2d: 0 = ACK, 1 = NACK (set tx_err). Go to wait_rel.
- wait_rel: wait until filtered ps2c=1 and synchronised ps2d=1. Then pulse tx_done_tick and go to idle.
- Timeout: if the counter expires in start, data, stop or wait_rel, release both lines, set tx_err=1, pulse tx_done_tick, go to idle.
- tx_idle=0 in every state except idle.
- wr_ps2 while busy is dropped with no side effect. wr_ps2 on the same cycle as the tx_done_tick return to idle is also dropped.
- A fall_edge during rts is ignored.
- Minimum transfer length: RTS_CYCLES + 11 device clocks.

Optional Feature:
Macro PS2_TX_RETRY_EN.
- Defined: on the first NACK or timeout of a transfer, do not pulse tx_done_tick. Wait one RTS_CYCLES interval with both lines released, then restart from rts with the same latched byte. A second failure sets tx_err and pulses tx_done_tick. At most one retry per wr_ps2.
- Undefined: single attempt, behaviour exactly as above.

Test Plan:
Simulation settings for all scenarios: RTS_CYCLES=20, FILTER_LEN=3, TIMEOUT_CYCLES=5000; device model clock period 200 cycles.
1. Reset, then wr_ps2 with din=0xED -> ps2c_oe=1 for 20 cycles, then ps2d_oe=1. Device samples on rising edges 0,1,0,1,1,0,1,1,1, parity=1, stop=1. Model ACKs low -> tx_done_tick once, tx_err=0, tx_idle back to 1.
2. din=0xF4 -> parity bit 0. din=0x00 -> parity bit 1. Both complete with tx_err=0.
3. Model holds ps2d high at fall 11 (NACK) -> tx_err=1 with tx_done_tick. A following wr_ps2 with 0xFF clears tx_err at acceptance.
4. Model never clocks after rts -> after 5000 cycles both oe=0, tx_err=1, tx_done_tick pulses.
5. wr_ps2 pulsed again during data -> ignored; only one byte is observed on the wire. reset_n low in the middle of data -> both oe=0 asynchronously, tx_idle=1.
6. Glitches of 1-2 cycles on ps2c_in during data -> no extra bit shifted; the byte is received correctly. With PS2_TX_RETRY_EN, a first NACK then an ACK -> two frames with identical bits, tx_err=0.
